// File: rtl/branch_predict_unit.sv
// EX-stage branch resolver with a PC-indexed 2-bit saturating-counter
// direction table, registered flush/redirect and performance counters.
module branch_predict_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [XLEN-1:0]      if_pc,
  output logic                 if_pred_taken,
  input  logic                 ex_valid,
  input  logic [XLEN-1:0]      ex_pc,
  input  logic [3:0]           ex_op,
  input  logic [XLEN-1:0]      ex_data1,
  input  logic [XLEN-1:0]      ex_data2,
  input  logic [XLEN-1:0]      ex_target,
  input  logic                 ex_pred_taken,
  output logic                 flush,
  output logic [XLEN-1:0]      redirect_pc,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam int IDX_BITS = $clog2(BHT_ENTRIES);

  // Low three bits of the branch op (bit 3 is the branch/jump enable)
  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_JUMP = 3'b010;
  localparam logic [2:0] OP_RSVD = 3'b011;
  localparam logic [2:0] OP_BLT  = 3'b100;
  localparam logic [2:0] OP_BGE  = 3'b101;
  localparam logic [2:0] OP_BLTU = 3'b110;
  localparam logic [2:0] OP_BGEU = 3'b111;

  localparam logic [1:0] CNT_RESET = 2'b01;  // weakly not-taken

  // Word-aligned PCs: drop the two byte-offset bits before indexing
  logic [IDX_BITS-1:0] if_idx;
  logic [IDX_BITS-1:0] ex_idx;
  assign if_idx = if_pc[IDX_BITS+1:2];
  assign ex_idx = ex_pc[IDX_BITS+1:2];

  // Bits of the fetch PC that play no part in the table lookup
  logic unused_if_pc_bits;
  assign unused_if_pc_bits = ^{if_pc[XLEN-1:IDX_BITS+2], if_pc[1:0]};

  // Registered state
  logic                 flush_q, flush_d;
  logic [XLEN-1:0]      redirect_q, redirect_d;
  logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;

  // Current value of every table entry, gathered from the per-entry flops
  logic [1:0] bht_cnt [BHT_ENTRIES];

  // Resolution results
  logic       taken;
  logic       is_branch;
  logic       active;
  logic       mispredict;
  logic [1:0] upd_cnt;

  // Direction resolution and branch classification for the EX instruction
  always_comb begin
    taken     = 1'b0;
    is_branch = ex_op[3] && (ex_op[2:0] != OP_RSVD);
    if (ex_op[3]) begin
      case (ex_op[2:0])
        OP_BEQ:  taken = (ex_data1 == ex_data2);
        OP_BNE:  taken = (ex_data1 != ex_data2);
        OP_JUMP: taken = 1'b1;
        OP_BLT:  taken = ($signed(ex_data1) <  $signed(ex_data2));
        OP_BGE:  taken = ($signed(ex_data1) >= $signed(ex_data2));
        OP_BLTU: taken = (ex_data1 <  ex_data2);
        OP_BGEU: taken = (ex_data1 >= ex_data2);
        default: taken = 1'b0;
      endcase
    end
    // The cycle after a flush holds a wrong-path instruction: ignore it
    active     = ex_valid && !flush_q && is_branch;
    mispredict = active && (taken != ex_pred_taken);
  end

  // Saturating next value for the entry addressed by the EX instruction
  always_comb begin
    upd_cnt = bht_cnt[ex_idx];
    if (taken) begin
      if (bht_cnt[ex_idx] != 2'b11) upd_cnt = bht_cnt[ex_idx] + 2'd1;
    end else begin
      if (bht_cnt[ex_idx] != 2'b00) upd_cnt = bht_cnt[ex_idx] - 2'd1;
    end
  end

  // One flop pair per table entry; only the addressed entry moves
  generate
    for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : gen_bht
      logic [1:0] cnt_q, cnt_d;

      // Load the saturated value when this entry is the active target
      always_comb begin
        cnt_d = cnt_q;
        if (active && (ex_idx == IDX_BITS'(gi))) cnt_d = upd_cnt;
      end

      // Entry register, reset to weakly not-taken
      always_ff @(posedge clk) begin
        if (reset) cnt_q <= CNT_RESET;
        else       cnt_q <= cnt_d;
      end

      assign bht_cnt[gi] = cnt_q;
    end
  endgenerate

  // Fetch-side prediction reads the pre-update value (write lands at the edge)
  assign if_pred_taken = bht_cnt[if_idx][1];

  // Next-state for flush, redirect target and performance counters
  always_comb begin
    flush_d       = mispredict;
    redirect_d    = redirect_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (mispredict) begin
      redirect_d = taken ? ex_target : (ex_pc + XLEN'(4));
    end
    if (active) begin
      branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
    end
    if (mispredict) begin
      mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(1);
    end
  end

  // Output and counter registers; reset wins over any in-flight mispredict
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_q       <= 1'b0;
      redirect_q    <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      flush_q       <= flush_d;
      redirect_q    <= redirect_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign flush            = flush_q;
  assign redirect_pc      = redirect_q;
  assign branch_count     = branch_cnt_q;
  assign mispredict_count = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed vector table,
// hand-written corner sequences and randomized traffic against a model.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [3:0]  ex_op;
  logic [31:0] ex_data1, ex_data2, ex_target;
  logic        ex_pred_taken;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count, mispredict_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predict_unit #(.XLEN(32), .BHT_ENTRIES(64), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op(ex_op), .ex_data1(ex_data1),
    .ex_data2(ex_data2), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .flush(flush), .redirect_pc(redirect_pc), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [3:0] op,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] tgt, input logic pred, input logic [31:0] ipc);
    ex_valid = v; ex_pc = pc; ex_op = op; ex_data1 = d1; ex_data2 = d2;
    ex_target = tgt; ex_pred_taken = pred; if_pc = ipc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- behavioural reference model ----------------
  int          m_bht [64];
  bit          m_flush;
  logic [31:0] m_redir;
  logic [31:0] m_bc, m_mc;

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
    m_flush = 0; m_redir = 0; m_bc = 0; m_mc = 0;
  endfunction

  function automatic bit ref_taken(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[3]) return 0;
    case (op[2:0])
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return 1;
      3'd4: return $signed(a) <  $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a <  b;
      3'd7: return a >= b;
      default: return 0;
    endcase
  endfunction

  function automatic void model_step();
    bit act, t, mis;
    int i;
    act = ex_valid && !m_flush && ex_op[3] && (ex_op[2:0] != 3'd3);
    t   = ref_taken(ex_op, ex_data1, ex_data2);
    mis = act && (t != ex_pred_taken);
    if (mis) m_redir = t ? ex_target : ex_pc + 32'd4;
    m_flush = mis;
    if (act) begin
      i = int'((ex_pc / 4) % 64);
      m_bht[i] = t ? ((m_bht[i] + 1 > 3) ? 3 : m_bht[i] + 1)
                   : ((m_bht[i] - 1 < 0) ? 0 : m_bht[i] - 1);
      m_bc = m_bc + 1;
      if (mis) m_mc = m_mc + 1;
    end
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [3:0]  op;
    logic [31:0] d1, d2, tgt;
    logic        pred;
    logic [31:0] ipc;
    logic        e_flush;
    logic [31:0] e_redir, e_bc, e_mc;
    logic        e_ifp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic v, input logic [31:0] pc, input logic [3:0] op,
                              input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] tgt,
                              input logic pred, input logic [31:0] ipc, input logic ef,
                              input logic [31:0] er, input logic [31:0] ebc, input logic [31:0] emc,
                              input logic eifp, input string name);
    vec_t x;
    x.v = v; x.pc = pc; x.op = op; x.d1 = d1; x.d2 = d2; x.tgt = tgt; x.pred = pred;
    x.ipc = ipc; x.e_flush = ef; x.e_redir = er; x.e_bc = ebc; x.e_mc = emc;
    x.e_ifp = eifp; x.name = name;
    vecs.push_back(x);
  endfunction

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);

    // Reset: state and full if_pc sweep
    do_reset();
    chk("reset_flush", {31'b0, flush}, 32'h0);
    chk("reset_redirect", redirect_pc, 32'h0);
    chk("reset_bcount", branch_count, 32'h0);
    chk("reset_mcount", mispredict_count, 32'h0);
    begin
      int bad = 0;
      for (int a = 0; a <= 32'hFC; a += 4) begin
        if_pc = a;
        #1;
        if (if_pred_taken !== 1'b0) bad++;
      end
      chk("reset_pred_sweep_bad", bad, 32'h0);
    end
    $display("reset sequence done");

    //  v  pc            op     d1            d2            tgt          pred ipc           fl redir        bc mc ifp
    add(1, 32'h40,       4'h9,  32'd1,        32'd2,        32'h20,      0,   32'h40,       1, 32'h20,      1, 1, 1, "bne_train1");
    add(0, 32'h40,       4'h9,  32'd1,        32'd2,        32'h20,      0,   32'h40,       0, 32'h20,      1, 1, 1, "bubble1");
    add(1, 32'h40,       4'h9,  32'd1,        32'd2,        32'h20,      1,   32'h40,       0, 32'h20,      2, 1, 1, "bne_train2");
    add(1, 32'h40,       4'h9,  32'd1,        32'd2,        32'h20,      1,   32'h40,       0, 32'h20,      3, 1, 1, "bne_train3");
    add(1, 32'h40,       4'h8,  32'd5,        32'd6,        32'h20,      1,   32'h40,       1, 32'h44,      4, 2, 1, "beq_nt_mispred");
    add(1, 32'h40,       4'hC,  32'hFFFFFFFF, 32'd1,        32'h80,      0,   32'h40,       0, 32'h44,      4, 2, 1, "blt_in_shadow");
    add(1, 32'h100,      4'hC,  32'hFFFFFFFF, 32'd1,        32'h200,     0,   32'h100,      1, 32'h200,     5, 3, 1, "blt_signed");
    add(0, 32'h0,        4'h0,  32'd0,        32'd0,        32'h0,       0,   32'h104,      0, 32'h200,     5, 3, 0, "bubble2");
    add(1, 32'h104,      4'hE,  32'hFFFFFFFF, 32'd1,        32'h300,     0,   32'h104,      0, 32'h200,     6, 3, 0, "bltu_unsigned");
    add(1, 32'h108,      4'hF,  32'hFFFFFFFF, 32'd1,        32'h400,     0,   32'h108,      1, 32'h400,     7, 4, 1, "bgeu_unsigned");
    add(0, 32'h0,        4'h0,  32'd0,        32'd0,        32'h0,       0,   32'h108,      0, 32'h400,     7, 4, 1, "bubble3");
    add(1, 32'h10C,      4'hA,  32'd0,        32'd0,        32'h100,     0,   32'h10C,      1, 32'h100,     8, 5, 1, "jal");
    add(0, 32'h0,        4'h0,  32'd0,        32'd0,        32'h0,       0,   32'h110,      0, 32'h100,     8, 5, 0, "bubble4");
    add(1, 32'h110,      4'hB,  32'd3,        32'd3,        32'h500,     1,   32'h110,      0, 32'h100,     8, 5, 0, "op_1011");
    add(1, 32'h110,      4'h2,  32'd3,        32'd3,        32'h500,     1,   32'h110,      0, 32'h100,     8, 5, 0, "op_0010");
    add(1, 32'h114,      4'hD,  32'd1,        32'hFFFFFFFF, 32'h600,     1,   32'h114,      0, 32'h100,     9, 5, 1, "bge_signed");
    add(1, 32'hFFFFFFFC, 4'h9,  32'd7,        32'd7,        32'h700,     1,   32'hFFFFFFFC, 1, 32'h0,      10, 6, 0, "bne_pc_wrap");

    foreach (vecs[k]) begin
      drive(vecs[k].v, vecs[k].pc, vecs[k].op, vecs[k].d1, vecs[k].d2,
            vecs[k].tgt, vecs[k].pred, vecs[k].ipc);
      tick();
      chk({vecs[k].name, "_flush"}, {31'b0, flush}, {31'b0, vecs[k].e_flush});
      chk({vecs[k].name, "_redirect"}, redirect_pc, vecs[k].e_redir);
      chk({vecs[k].name, "_bcount"}, branch_count, vecs[k].e_bc);
      chk({vecs[k].name, "_mcount"}, mispredict_count, vecs[k].e_mc);
      chk({vecs[k].name, "_ifpred"}, {31'b0, if_pred_taken}, {31'b0, vecs[k].e_ifp});
      $display("vector %0d %s flush=%0b redirect=%h bc=%0d mc=%0d", k, vecs[k].name,
               flush, redirect_pc, branch_count, mispredict_count);
    end

    // Same-index read/update: IF sees the old counter until the edge
    drive(1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h80);
    tick();
    drive(1'b1, 32'h80, 4'h8, 32'd9, 32'd9, 32'h900, 1'b1, 32'h80);
    #1;
    chk("same_idx_before", {31'b0, if_pred_taken}, 32'h0);
    tick();
    chk("same_idx_after", {31'b0, if_pred_taken}, 32'h1);
    chk("same_idx_noflush", {31'b0, flush}, 32'h0);
    $display("same-index sequence done");

    // Reset asserted alongside a mispredicting branch
    drive(1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h80);
    tick();
    drive(1'b1, 32'h40, 4'h9, 32'd1, 32'd2, 32'h20, 1'b0, 32'h80);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h80);
    #1;
    chk("midreset_flush", {31'b0, flush}, 32'h0);
    chk("midreset_redirect", redirect_pc, 32'h0);
    chk("midreset_bcount", branch_count, 32'h0);
    chk("midreset_mcount", mispredict_count, 32'h0);
    chk("midreset_ifpred", {31'b0, if_pred_taken}, 32'h0);
    $display("mid-operation reset sequence done");

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int n = 0; n < 400; n++) begin
      logic [31:0] d1, d2, pc;
      d1 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3)) - 32'd1;
      d2 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3)) - 32'd1;
      pc = ($urandom_range(0, 7) == 0) ? $urandom : {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
      drive(1'($urandom_range(0, 4) != 0), pc, 4'($urandom), d1, d2, $urandom,
            1'($urandom), {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00});
      #1;
      chk("rand_ifpred", {31'b0, if_pred_taken}, {31'b0, 1'(m_bht[(if_pc / 4) % 64] >= 2)});
      model_step();
      tick();
      chk("rand_flush", {31'b0, flush}, {31'b0, m_flush});
      chk("rand_redirect", redirect_pc, m_redir);
      chk("rand_bcount", branch_count, m_bc);
      chk("rand_mcount", mispredict_count, m_mc);
      $display("rand %0d op=%h pc=%h flush=%0b redirect=%h bc=%0d mc=%0d", n, ex_op, ex_pc,
               flush, redirect_pc, branch_count, mispredict_count);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
Next-generation EX-stage branch resolver for the RV32IM pipeline, parametrised in data width and predictor depth. It resolves BEQ/BNE/BLT/BGE/BLTU/BGEU and JAL/JALR from the 4-bit branch op. It also holds a PC-indexed table of 2-bit saturating counters that IF reads for a direction prediction. On a wrong prediction it issues a registered flush/redirect, squashes the wrong-path shadow and keeps performance counters.

Parameters:
XLEN, 32, operand and PC width
BHT_ENTRIES, 64, number of 2-bit counters (power of 2, >=2)
IDX_BITS, $clog2(BHT_ENTRIES), table index width (derived)
CNT_WIDTH, 32, width of performance counters

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
if_pc  in  XLEN  PC of the instruction currently in IF
if_pred_taken  out  1  predicted direction for if_pc (combinational table read)
ex_valid  in  1  EX holds a real instruction
ex_pc  in  XLEN  PC of the EX instruction
ex_op  in  4  branch op: bit3=branch/jump enable; [2:0] 010 jump, 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
ex_data1  in  XLEN  rs1 operand
ex_data2  in  XLEN  rs2 operand
ex_target  in  XLEN  computed branch/jump target
ex_pred_taken  in  1  prediction carried down the pipe with this instruction
flush  out  1  registered: squash IF/ID and redirect fetch
redirect_pc  out  XLEN  registered: correct next PC when flush=1
branch_count  out  CNT_WIDTH  resolved branch/jump instructions
mispredict_count  out  CNT_WIDTH  resolved mispredictions

Behaviour:
- Index = pc[IDX_BITS+1:2] for both the IF read and the EX update.
- if_pred_taken = MSB of counter[index(if_pc)], purely combinational.
- Resolution (combinational, internal):
  - taken = 0 when ex_op[3]=0.
  - Jump (010): taken = 1.
  - Compares: signed for BLT/BGE, unsigned for BLTU/BGEU.
  - Codes 011: taken = 0, and the instruction is treated as a non-branch.
- Active instruction: ex_valid=1, flush=0, ex_op[3]=1, ex_op[2:0]!=011.
  - flush=1 marks the squash shadow. In that cycle the EX input is ignored entirely: no update, no count, no flush.
- Mispredict: active and (taken != ex_pred_taken).
- Registered outputs, 1-cycle latency. At each rising edge:
  - flush <= mispredict.
  - redirect_pc <= taken ? ex_target : ex_pc+4, with ex_pc+4 taken modulo 2^XLEN.
  - redirect_pc holds its last value when flush <= 0.
- Table update at the same edge when active:
  - Taken: counter <= min(counter+1, 3).
  - Not taken: counter <= max(counter-1, 0).
  - Jumps update like taken branches.
- Same-cycle IF read and EX update of the same index: IF sees the old value; the new value is visible the next cycle.
- Counters:
  - branch_count increments on every active instruction.
  - mispredict_count increments on every mispredict.
  - Both wrap modulo 2^CNT_WIDTH.
- Reset (synchronous, priority over all other activity, including mid-flush):
  - All counters set to 2'b01 (weakly not-taken).
  - flush=0, redirect_pc=0, branch_count=0, mispredict_count=0.
  - if_pred_taken therefore reads 0 for every PC the cycle after reset.
- Back-to-back mispredicts: an instruction in the shadow cycle can never flush, so flush never stays high for two consecutive cycles.

Test Plan:
- Reset: hold reset 2 cycles, then sweep if_pc 0x0..0xFC -> if_pred_taken=0, flush=0, redirect_pc=0, both counts 0.
- Train loop: 3× BNE at pc=0x40 (data1=1, data2=2, pred=0, target=0x20).
  - Cycle 1 -> flush=1, redirect_pc=0x20, counter 01->10.
  - if_pc=0x40 then gives if_pred_taken=1.
  - Remaining two -> counter saturates at 11.
  - Final state: branch_count=3, mispredict_count=1.
- Not-taken mispredict: BEQ pc=0x40 (data1=5, data2=6, pred=1) -> flush=1, redirect_pc=0x44, counter 11->10.
  - The following cycle, a BLT with pred=0 that would be taken is ignored: flush=0, counts unchanged.
- Signed vs unsigned: data1=0xFFFFFFFF, data2=1.
  - BLT -> taken.
  - BLTU -> not taken.
  - BGEU -> taken.
  - Check flush/redirect against pred=0.
- Jump and invalid op:
  - JAL (op=1010, pred=0, target=0x100) -> flush=1, redirect_pc=0x100.
  - op=1011 -> no flush, no count, no table change.
  - op=0xxx with ex_valid=1 -> no effect.
- Same-index read/update: if_pc=ex_pc=0x80, counter=01, taken update -> if_pred_taken=0 that cycle and 1 the next cycle.
- Reset mid-operation: assert reset in the same cycle as a mispredicting branch -> flush=0 and counts=0 after the edge.
